zap_ram_fifo_fwft: RTL and testbench

//  First-word-fall-through synchronous FIFO built on one zap_ram_simple_nopipe instance.

---
 rtl/zap_ram_fifo_fwft.sv | 173 +++++++++++++++++
 tb/tb_zap_ram_fifo_fwft.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/zap_ram_fifo_fwft.sv
// zap_ram_fifo_fwft -- first-word-fall-through synchronous FIFO.
//
// One zap_ram_simple_nopipe instance holds the bulk storage. Its one-cycle
// read latency is hidden by a 2-entry output skid buffer. The FIFO sustains
// one push plus one pop per cycle. Total capacity is DEPTH+2.
//
// Parameters:
//   WIDTH  data width in bits (>=1)
//   DEPTH  RAM entries (power of 2, >=4)
//
// Ports:
//   i_clk      clock, all flops on posedge
//   i_reset_n  asynchronous active-low reset
//   i_wr_en    push request; ignored while o_full
//   i_wr_data  push data
//   o_full     registered; 1 when the RAM holds DEPTH entries
//   i_rd_en    pop request; consumes o_rd_data; ignored while o_empty
//   o_rd_data  head of queue (skid entry 0), valid when !o_empty
//   o_empty    1 when the skid buffer is empty
//   o_count    total occupancy: RAM + read in flight + skid
//   o_err      sticky misuse flag (push-while-full / pop-while-empty)
//
// Build option:
//   ZAP_FIFO_ERR_EN  when defined, o_err is a sticky flag cleared only by
//                    reset; otherwise o_err is tied to 0.

module zap_ram_simple_nopipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write-first on a same-address collision. The FIFO never relies on this.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    if (i_rd_en) rd_data_q <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data
                                                                    : mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

module zap_ram_fifo_fwft #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 2) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_err
);

  localparam logic [AW:0] RAM_FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      ram_cnt_q, ram_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic [WIDTH-1:0] skid0_q, skid0_d;
  logic [WIDTH-1:0] skid1_q, skid1_d;
  logic             full_q, full_d;

  logic             push, pop, issue;
  logic [2:0]       pending;
  logic [1:0]       post_pop_cnt;
  logic [WIDTH-1:0] ram_rdata;

  zap_ram_simple_nopipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (push),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_wr_data),
    .i_rd_en   (issue),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (ram_rdata)
  );

  always_comb begin
    push    = i_wr_en & ~full_q;
    pop     = i_rd_en & (skid_cnt_q != 2'd0);
    // Skid slots still claimed after this edge; a read may issue only if
    // its data will find a free slot when it lands next cycle.
    pending = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (ram_cnt_q != '0) && (pending < 3'd2);

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(issue);
    ram_cnt_d  = ram_cnt_q + (AW + 1)'(push) - (AW + 1)'(issue);
    full_d     = (ram_cnt_d == RAM_FULL);
    inflight_d = issue;

    // Shift out the popped head first, then append the arriving RAM word
    // into the first free slot, all in one edge.
    post_pop_cnt = skid_cnt_q - {1'b0, pop};
    skid0_d      = pop ? skid1_q : skid0_q;
    skid1_d      = skid1_q;
    if (inflight_q) begin
      if (post_pop_cnt == 2'd0) skid0_d = ram_rdata;
      else                      skid1_d = ram_rdata;
    end
    skid_cnt_d = post_pop_cnt + {1'b0, inflight_q};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      skid_cnt_q <= '0;
      skid0_q    <= '0;
      skid1_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      skid_cnt_q <= skid_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      full_q     <= full_d;
    end
  end

  assign o_full    = full_q;
  assign o_empty   = (skid_cnt_q == 2'd0);
  assign o_rd_data = skid0_q;
  assign o_count   = CW'(ram_cnt_q) + CW'(inflight_q) + CW'(skid_cnt_q);

`ifdef ZAP_FIFO_ERR_EN
  logic err_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) err_q <= 1'b0;
    else            err_q <= err_q | (i_wr_en & full_q) | (i_rd_en & o_empty);
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // Reads need ram_cnt!=0 and writes need ram_cnt!=DEPTH, so the RAM ports
  // can never address the same entry in one cycle.
  a_no_addr_conflict: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(push && issue && (wr_ptr_q == rd_ptr_q)));

endmodule

// File: tb/tb_zap_ram_fifo_fwft.sv
module tb_zap_ram_fifo_fwft;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 2) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             full;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic [CW-1:0]    count;
  logic             err;

  always #5 clk = ~clk;

  zap_ram_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .o_full    (full),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_empty   (empty),
    .o_count   (count),
    .o_err     (err)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: occupancy split (RAM / in flight / skid) and data queue.
  int unsigned      m_ram, m_inf, m_skid;
  bit               m_err;
  logic [WIDTH-1:0] sb_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ram = 0; m_inf = 0; m_skid = 0; m_err = 1'b0;
    sb_q.delete();
  endtask

  // Called one time unit after an edge: compare outputs with the model,
  // apply inputs across the next edge, then advance the model.
  task automatic drive_cycle(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bit m_full, m_empty, acc_push, acc_pop, iss;
    m_full  = (m_ram == DEPTH);
    m_empty = (m_skid == 0);
    check_val("empty", 64'(empty), 64'(m_empty));
    check_val("full",  64'(full),  64'(m_full));
    check_val("count", 64'(count), 64'(m_ram + m_inf + m_skid));
    check_val("err",   64'(err),   64'(m_err));
    if (!m_empty && sb_q.size() != 0) check_val("data", 64'(rd_data), 64'(sb_q[0]));
    wr_en = wr; rd_en = rd; wr_data = d;
    @(posedge clk);
    acc_push = wr && !m_full;
    acc_pop  = rd && !m_empty;
    iss      = (m_ram != 0) && ((m_skid + m_inf - int'(acc_pop)) < 2);
`ifdef ZAP_FIFO_ERR_EN
    if ((wr && m_full) || (rd && m_empty)) m_err = 1'b1;
`endif
    m_skid = m_skid - int'(acc_pop) + m_inf;
    m_inf  = int'(iss);
    m_ram  = m_ram + int'(acc_push) - int'(iss);
    if (acc_push) sb_q.push_back(d);
    if (acc_pop && sb_q.size() != 0) void'(sb_q.pop_front());
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_empty", 64'(empty), 64'd1);
    check_val("rst_count", 64'(count), 64'd0);
    check_val("rst_full",  64'(full),  64'd0);
    check_val("rst_err",   64'(err),   64'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 8; i++) begin
      if (m_ram + m_inf + m_skid == 0) break;
      drive_cycle(1'b0, 1'b1, '0);
    end
    check_val("drained", 64'(m_ram + m_inf + m_skid), 64'd0);
  endtask

  initial begin
    logic exp_err;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    check_val("rst_data", 64'(rd_data), 64'd0);

    // Single push: fall-through after two more edges.
    drive_cycle(1'b1, 1'b0, 32'hA5);
    check_val("t1_count", 64'(count), 64'd1);
    drive_cycle(1'b0, 1'b0, '0);
    check_val("t1_empty_e2", 64'(empty), 64'd1);
    drive_cycle(1'b0, 1'b0, '0);
    check_val("t1_empty_e3", 64'(empty), 64'd0);
    check_val("t1_data", 64'(rd_data), 64'hA5);
    drive_cycle(1'b0, 1'b1, '0);

    // Fill to DEPTH+2, the 19th push dropped.
    for (int i = 0; i < int'(DEPTH) + 3; i++) drive_cycle(1'b1, 1'b0, WIDTH'(i));
    check_val("t2_full",  64'(full),  64'd1);
    check_val("t2_count", 64'(count), 64'(DEPTH + 2));
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      check_val("t2_order", 64'(rd_data), 64'(i));
      drive_cycle(1'b0, 1'b1, '0);
    end
    check_val("t2_empty", 64'(empty), 64'd1);

    // Pop while empty.
    drive_cycle(1'b0, 1'b1, '0);
`ifdef ZAP_FIFO_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check_val("t4_err", 64'(err), 64'(exp_err));
    check_val("t4_count", 64'(count), 64'd0);

    // Fill 8, then steady push+pop.
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, WIDTH'(32'h100 + i));
    for (int i = 0; i < 100; i++) begin
      check_val("t3_count", 64'(count), 64'd8);
      check_val("t3_seq", 64'(rd_data), 64'(32'h100 + i));
      drive_cycle(1'b1, 1'b1, WIDTH'(32'h108 + i));
    end
    drain();

    // Mid-stream reset with 5 entries, one read in flight.
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, WIDTH'(32'h200 + i));
    drive_cycle(1'b0, 1'b1, '0);
    check_val("t5_count_pre", 64'(count), 64'd5);
    do_reset();
    drive_cycle(1'b1, 1'b0, 32'h3C);
    drive_cycle(1'b0, 1'b0, '0);
    drive_cycle(1'b0, 1'b0, '0);
    check_val("t5_first", 64'(rd_data), 64'h3C);
    check_val("t5_empty", 64'(empty), 64'd0);
    drain();

    // Random traffic with shifting push/pop bias to visit full and empty.
    for (int blk = 0; blk < 20; blk++) begin
      int unsigned pw, pr;
      pw = (blk % 3 == 0) ? 90 : (blk % 3 == 1) ? 20 : 55;
      pr = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 90 : 55;
      for (int c = 0; c < 500; c++) begin
        drive_cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), $urandom);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
